multicycle_cu: RTL

- Parametrised successor to the single-cycle control unit: a Moore FSM that sequences one RV32I instruction over 3–5 cycles on a shared memory and ALU datapath.
- Sits between the instruction register and the multi-cycle datapath.
- Adds what the single-cycle unit lacks: instruction fetch/decode sequencing, a memory-ready stall handshake, BNE, JAL, I-type ALU ops, and a sticky illegal-opcode trap.

---
 rtl/multicycle_cu.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch, decode and
// execute phases over a shared memory/ALU datapath, with a sticky trap state.
module multicycle_cu #(
    parameter bit          ENABLE_BNE = 1'b1,
    parameter bit          ENABLE_JAL = 1'b1,
    parameter int unsigned ALUC_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic [2:0]        fun3,
    input  logic              fun7,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              adr_src,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic [1:0]        result_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        imm_src,
    output logic [ALUC_W-1:0] alu_control,
    output logic [3:0]        state_o,
    output logic              instr_done,
    output logic              illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       done_raw;
    logic       branch_taken;
    logic [1:0] aluop;
    logic [2:0] alu_ctl;

    // State register; reset may land mid-instruction and always returns to FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    assign branch_taken = ((fun3 == F3_BEQ) && zero) || ((fun3 == F3_BNE) && !zero);

    // Next-state and datapath controls.
    always_comb begin
        state_nxt     = state;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = 2'b00;
        aluop         = 2'b00;

        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_JAL:            state_nxt = ENABLE_JAL ? S_JAL : S_TRAP;
                    OP_BRANCH: begin
                        if ((fun3 == F3_BEQ) || (ENABLE_BNE && (fun3 == F3_BNE))) begin
                            state_nxt = S_BRANCH;
                        end else begin
                            state_nxt = S_TRAP;
                        end
                    end
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_STORE) begin
                    imm_src   = 2'b01;
                    state_nxt = S_MEMWRITE;
                end else begin
                    state_nxt = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) begin
                    done_raw  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                aluop     = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop     = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                imm_src      = 2'b11;
                pc_write_raw = 1'b1;
                state_nxt    = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a    = 2'b10;
                aluop        = 2'b01;
                pc_write_raw = branch_taken;
                done_raw     = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_TRAP;
            end
        endcase
    end

    // ALU operation decode; only addi-style ops ignore fun7 since opcode[5] is 0.
    always_comb begin
        alu_ctl = 3'b000;
        case (aluop)
            2'b01: alu_ctl = 3'b001;
            2'b10: begin
                case (fun3)
                    3'b000:  alu_ctl = ({opcode[5], fun7} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctl = 3'b101;
                    3'b110:  alu_ctl = 3'b011;
                    3'b111:  alu_ctl = 3'b010;
                    default: alu_ctl = 3'b000;
                endcase
            end
            default: alu_ctl = 3'b000;
        endcase
    end

    assign alu_control = ALUC_W'(alu_ctl);
    assign state_o     = state;

    // Strobes are forced low during any reset cycle.
    assign pc_write   = pc_write_raw & rst_n;
    assign mem_write  = mem_write_raw & rst_n;
    assign ir_write   = ir_write_raw & rst_n;
    assign reg_write  = reg_write_raw & rst_n;
    assign instr_done = done_raw & rst_n;
    assign illegal    = (state == S_TRAP) & rst_n;

endmodule
